// File: rtl/fas_seq_ctrl.sv
// fas_seq_ctrl: fills a 2-bank ping-pong frame buffer from FIR samples, launches one FFT per
// full frame, then runs the analysis handshake. Define FAS_SEQ_ANALYSIS_EN to include the ANA stage.
module fas_seq_ctrl #(
  parameter int FRAME_LEN  = 16,
  parameter int NUM_FRAMES = 64,
  parameter int ADDR_W     = 4,
  parameter int CNT_W      = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fir_valid,
  input  logic              fft_busy,
  input  logic              fft_done,
  input  logic              ana_done,
  output logic              buf_wr_en,
  output logic              buf_wr_bank,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic              fft_start,
  output logic              fft_bank,
  output logic              fft_valid,
  output logic              ana_start,
  output logic              done,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              overrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd3;
`ifdef FAS_SEQ_ANALYSIS_EN
  localparam logic [1:0] S_ANA  = 2'd2;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(NUM_FRAMES);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [1:0]        r_bank_full;
  logic              r_fft_start;
  logic              r_fft_bank;
  logic              r_fft_valid;
  logic              r_done;
  logic              r_overrun;
  logic [CNT_W-1:0]  r_frame_cnt;
  logic [CNT_W-1:0]  w_cnt_next;

  logic              w_wr_en;
  logic              w_drop;
  logic              w_last_wr;
  logic              w_launch;
  logic              w_retire;
  logic              w_last_frame;
  logic              w_done_set;
  logic [1:0]        w_set;
  logic [1:0]        w_clr;

  // Writes are only accepted into a bank the FFT has released; rst gating keeps the strobe low in reset.
  assign w_wr_en   = fir_valid & ~r_bank_full[r_wr_bank] & ~r_done & rst;
  assign w_drop    = fir_valid &  r_bank_full[r_wr_bank] & ~r_done;
  assign w_last_wr = w_wr_en & (r_wr_addr == LAST_ADDR);

  assign w_set = {w_last_wr & r_wr_bank, w_last_wr & ~r_wr_bank};
  assign w_clr = {w_retire  & r_rd_bank, w_retire  & ~r_rd_bank};

  assign w_cnt_next   = (r_frame_cnt == LAST_CNT) ? r_frame_cnt : (r_frame_cnt + CNT_W'(1));
  assign w_last_frame = (w_cnt_next == LAST_CNT);

  // Sequencer next-state and per-cycle launch/retire decisions
  always_comb begin
    w_next_state = r_state;
    w_launch     = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_bank_full[r_rd_bank] & ~fft_busy) begin
          w_launch     = 1'b1;
          w_next_state = S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN: begin
        if (fft_done) begin
          w_retire = 1'b1;
          if (w_last_frame) begin
`ifdef FAS_SEQ_ANALYSIS_EN
            w_next_state = S_ANA;
`else
            w_next_state = S_FIN;
`endif
          end else begin
            w_next_state = S_IDLE;
          end
        end else begin
          w_next_state = S_RUN;
        end
      end
`ifdef FAS_SEQ_ANALYSIS_EN
      S_ANA: begin
        if (ana_done) begin
          w_next_state = S_FIN;
        end else begin
          w_next_state = S_ANA;
        end
      end
`endif
      S_FIN: begin
        w_next_state = S_FIN;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // done follows ana_done directly; without analysis it trails the last fft_valid by a cycle
`ifdef FAS_SEQ_ANALYSIS_EN
  assign w_done_set = (r_state == S_FIN) | ((r_state == S_ANA) & ana_done);
`else
  assign w_done_set = (r_state == S_FIN);
`endif

  // Write pointer, bank occupancy and sticky overrun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_addr   <= {ADDR_W{1'b0}};
      r_wr_bank   <= 1'b0;
      r_bank_full <= 2'b00;
      r_overrun   <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_addr <= w_last_wr ? {ADDR_W{1'b0}} : (r_wr_addr + ADDR_W'(1));
        if (w_last_wr) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end
      r_bank_full <= (r_bank_full | w_set) & ~w_clr;
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // FSM state, FFT handshake pulses, read bank and frame counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_fft_start <= 1'b0;
      r_fft_bank  <= 1'b0;
      r_fft_valid <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_frame_cnt <= {CNT_W{1'b0}};
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_fft_start <= w_launch;
      r_fft_valid <= w_retire;
      if (w_launch) begin
        r_fft_bank <= r_rd_bank;
      end
      if (w_retire) begin
        r_rd_bank   <= ~r_rd_bank;
        r_frame_cnt <= w_cnt_next;
      end
      if (w_done_set) begin
        r_done <= 1'b1;
      end
    end
  end

`ifdef FAS_SEQ_ANALYSIS_EN
  logic r_ana_start;

  // Analysis launch pulse issued alongside the final frame's fft_valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ana_start <= 1'b0;
    end else begin
      r_ana_start <= w_retire & w_last_frame;
    end
  end

  assign ana_start = r_ana_start;
`else
  logic w_unused_ana;
  assign w_unused_ana = ana_done;
  assign ana_start    = 1'b0;
`endif

  assign buf_wr_en   = w_wr_en;
  assign buf_wr_bank = r_wr_bank;
  assign buf_wr_addr = r_wr_addr;
  assign fft_start   = r_fft_start;
  assign fft_bank    = r_fft_bank;
  assign fft_valid   = r_fft_valid;
  assign done        = r_done;
  assign frame_cnt   = r_frame_cnt;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_fas_seq_ctrl.sv
// Randomized bench for fas_seq_ctrl against a sample/frame counting reference model.
// Honours FAS_SEQ_ANALYSIS_EN the same way as the design.
module tb_fas_seq_ctrl;

  localparam int FL = 16;
  localparam int NF = 64;
`ifdef FAS_SEQ_ANALYSIS_EN
  localparam bit ANA_EN = 1'b1;
`else
  localparam bit ANA_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       fir_valid;
  logic       fft_busy;
  logic       fft_done;
  logic       ana_done;
  logic       buf_wr_en;
  logic       buf_wr_bank;
  logic [3:0] buf_wr_addr;
  logic       fft_start;
  logic       fft_bank;
  logic       fft_valid;
  logic       ana_start;
  logic       done;
  logic [6:0] frame_cnt;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: counts of accepted samples, launched and completed frames
  int m_acc, m_comp, m_launch, m_fbank;
  bit m_ana_wait, m_fin, m_done, m_ovr, m_start, m_valid, m_ana;

  // environment stubs and stimulus knobs
  int fft_timer, ana_timer;
  bit fft_pend, ana_pend;
  int p_fv, p_busy, fft_lat;
  bit spur, stop_full;
  int n_valid, n_ana;

  always #5 clk = ~clk;

  fas_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .fir_valid  (fir_valid),
    .fft_busy   (fft_busy),
    .fft_done   (fft_done),
    .ana_done   (ana_done),
    .buf_wr_en  (buf_wr_en),
    .buf_wr_bank(buf_wr_bank),
    .buf_wr_addr(buf_wr_addr),
    .fft_start  (fft_start),
    .fft_bank   (fft_bank),
    .fft_valid  (fft_valid),
    .ana_start  (ana_start),
    .done       (done),
    .frame_cnt  (frame_cnt),
    .overrun    (overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_comp = 0; m_launch = 0; m_fbank = 0;
    m_ana_wait = 1'b0; m_fin = 1'b0; m_done = 1'b0; m_ovr = 1'b0;
    m_start = 1'b0; m_valid = 1'b0; m_ana = 1'b0;
    fft_pend = 1'b0; ana_pend = 1'b0; fft_timer = 0; ana_timer = 0;
  endtask

  function automatic bit exp_wr(input bit fv);
    return fv && ((m_acc / FL - m_comp) < 2) && !m_done;
  endfunction

  // one clock edge of the reference behaviour
  task automatic model_step(input bit fv, input bit busy, input bit fdn, input bit adn);
    int fc;
    bit wr, idle, run, last, ana_fire;
    fc       = m_acc / FL - m_comp;
    wr       = fv && fc < 2 && !m_done;
    run      = m_launch > m_comp;
    idle     = !run && !m_ana_wait && !m_fin;
    m_start  = idle && fc >= 1 && !busy;
    m_valid  = run && fdn;
    last     = m_valid && (m_comp + 1 == NF);
    ana_fire = m_ana_wait && adn;
    m_ovr    = m_ovr || (fv && fc >= 2 && !m_done);
    m_done   = m_done || m_fin || ana_fire;
    m_fin    = m_fin || ana_fire || (last && !ANA_EN);
    m_ana    = last && ANA_EN;
    m_ana_wait = (m_ana_wait && !adn) || m_ana;
    if (m_start) begin
      m_fbank = m_comp % 2;
      m_launch++;
    end
    if (m_valid) m_comp++;
    if (wr) m_acc++;
  endtask

  task automatic check_all();
    check_eq("wr_bank",   32'(buf_wr_bank), 32'((m_acc / FL) % 2));
    check_eq("wr_addr",   32'(buf_wr_addr), 32'(m_acc % FL));
    check_eq("fft_start", 32'(fft_start),   32'(m_start));
    check_eq("fft_bank",  32'(fft_bank),    32'(m_fbank));
    check_eq("fft_valid", 32'(fft_valid),   32'(m_valid));
    check_eq("ana_start", 32'(ana_start),   32'(m_ana));
    check_eq("done",      32'(done),        32'(m_done));
    check_eq("frame_cnt", 32'(frame_cnt),   32'(m_comp));
    check_eq("overrun",   32'(overrun),     32'(m_ovr));
  endtask

  // entered and left on a falling edge
  task automatic step_cycle();
    bit fv, busy, fdn, adn;
    fdn  = 1'b0;
    adn  = 1'b0;
    busy = fft_pend || (int'($urandom_range(0, 99)) < p_busy);
    if (fft_pend) begin
      if (fft_timer == 0) begin
        fdn = 1'b1;
        fft_pend = 1'b0;
      end else begin
        fft_timer--;
      end
    end else if (spur && $urandom_range(0, 15) == 0) begin
      fdn = 1'b1;
    end
    if (ana_pend) begin
      if (ana_timer == 0) begin
        adn = 1'b1;
        ana_pend = 1'b0;
      end else begin
        ana_timer--;
      end
    end else if (spur && $urandom_range(0, 15) == 0) begin
      adn = 1'b1;
    end
    fv = (int'($urandom_range(0, 99)) < p_fv) && !(stop_full && m_acc >= NF * FL);
    fir_valid = fv; fft_busy = busy; fft_done = fdn; ana_done = adn;
    #1;
    check_eq("wr_en", 32'(buf_wr_en), 32'(exp_wr(fv)));
    @(posedge clk);
    model_step(fv, busy, fdn, adn);
    #1;
    check_all();
    if (fft_valid) n_valid++;
    if (ana_start) n_ana++;
    if (fft_start) begin
      fft_pend  = 1'b1;
      fft_timer = (fft_lat < 0) ? int'($urandom_range(3, 25)) : fft_lat;
    end
    if (ana_start) begin
      ana_pend  = 1'b1;
      ana_timer = int'($urandom_range(2, 6));
    end
    @(negedge clk);
  endtask

  // asynchronous assertion mid-cycle with busy inputs; outputs must clear at once
  task automatic do_reset();
    #2;
    rst = 1'b0;
    fir_valid = 1'b1; fft_done = 1'b1; ana_done = 1'b1; fft_busy = 1'b0;
    #1;
    check_eq("rst_wr_en",     32'(buf_wr_en),   32'd0);
    check_eq("rst_wr_bank",   32'(buf_wr_bank), 32'd0);
    check_eq("rst_wr_addr",   32'(buf_wr_addr), 32'd0);
    check_eq("rst_fft_start", 32'(fft_start),   32'd0);
    check_eq("rst_fft_bank",  32'(fft_bank),    32'd0);
    check_eq("rst_fft_valid", 32'(fft_valid),   32'd0);
    check_eq("rst_ana_start", 32'(ana_start),   32'd0);
    check_eq("rst_done",      32'(done),        32'd0);
    check_eq("rst_frame_cnt", 32'(frame_cnt),   32'd0);
    check_eq("rst_overrun",   32'(overrun),     32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_hold_valid", 32'(fft_valid), 32'd0);
    rst = 1'b1;
    fir_valid = 1'b0; fft_done = 1'b0; ana_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    fir_valid = 1'b0; fft_busy = 1'b0; fft_done = 1'b0; ana_done = 1'b0;
    p_fv = 100; p_busy = 0; fft_lat = 20; spur = 1'b0; stop_full = 1'b0;
    n_valid = 0; n_ana = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // back-to-back samples, FFT launched straight after the first frame fills
    repeat (40) step_cycle();

    // FFT engine busy across a bank-full edge, then released
    p_busy = 100;
    repeat (30) step_cycle();
    p_busy = 0;
    repeat (60) step_cycle();

    // long FFT with continuous input: both banks fill and samples drop
    fft_lat = 80;
    repeat (100) step_cycle();
    check_eq("overrun_seen", 32'(overrun), 32'd1);

    // reset in the middle of an FFT, then random traffic with stray done pulses
    do_reset();
    p_fv = 30; p_busy = 20; fft_lat = -1; spur = 1'b1;
    repeat (300) step_cycle();

    // complete run of NF frames
    do_reset();
    p_fv = 50; p_busy = 0; fft_lat = 20; stop_full = 1'b1;
    n_valid = 0; n_ana = 0;
    for (int i = 0; i < 20000 && !m_done; i++) step_cycle();
    check_eq("run_done",       32'(done),      32'd1);
    check_eq("run_frames",     32'(frame_cnt), 32'(NF));
    check_eq("run_fft_valids", 32'(n_valid),   32'(NF));
    check_eq("run_ana_starts", 32'(n_ana),     ANA_EN ? 32'd1 : 32'd0);
    check_eq("run_overrun",    32'(overrun),   32'd0);

    // after done, input samples are ignored
    stop_full = 1'b0; p_fv = 100;
    repeat (20) step_cycle();
    check_eq("post_done_ovr", 32'(overrun), 32'd0);

    // reset at sample 7 of frame 3
    do_reset();
    p_fv = 100; fft_lat = 10; spur = 1'b0;
    for (int i = 0; i < 600 && m_acc != 3 * FL + 7; i++) step_cycle();
    check_eq("f3_addr", 32'(buf_wr_addr), 32'd7);
    check_eq("f3_bank", 32'(buf_wr_bank), 32'd1);
    do_reset();
    repeat (24) step_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fas_seq_ctrl.md
Name: fas_seq_ctrl

Overview:
- Sequencer for the FAS datapath: FIR output samples → 16-point ping-pong frame buffer → FFT engine → frequency analysis.
- Generates buffer write controls from fir_valid and launches one FFT per full frame.
- Produces the frame-level fft_valid strobe, triggers final analysis after the last frame, and raises done.

Parameters:
- FRAME_LEN, 16: samples per FFT frame; power of two.
- NUM_FRAMES, 64: frames per run (1024 samples / 16).
- ADDR_W, 4: log2(FRAME_LEN).
- CNT_W, 7: frame counter width; must hold NUM_FRAMES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- fir_valid  in  1  FIR output sample valid this cycle.
- fft_busy  in  1  FFT engine busy.
- fft_done  in  1  one-cycle pulse: FFT finished the current frame.
- ana_done  in  1  one-cycle pulse: analysis finished.
- buf_wr_en  out  1  write strobe to the frame buffer.
- buf_wr_bank  out  1  bank being written.
- buf_wr_addr  out  ADDR_W  sample index within the bank.
- fft_start  out  1  one-cycle pulse: FFT consumes bank fft_bank.
- fft_bank  out  1  bank presented to the FFT; stable from fft_start until fft_done.
- fft_valid  out  1  one-cycle pulse: FFT outputs of the frame are valid.
- ana_start  out  1  one-cycle pulse: start analysis.
- done  out  1  run complete; held high until reset.
- frame_cnt  out  CNT_W  frames completed.
- overrun  out  1  sticky flag: a sample was dropped.

Behaviour:
- Reset (rst=0, async): all outputs 0; wr_bank=0, wr_addr=0, rd_bank=0, bank_full=2'b00, FSM=IDLE.
- Write side (combinational strobes, registered pointers):
  - buf_wr_en = fir_valid & !bank_full[wr_bank] & !done.
  - buf_wr_bank = wr_bank; buf_wr_addr = wr_addr.
  - Each accepted write increments wr_addr.
  - On the write at wr_addr = FRAME_LEN-1: set bank_full[wr_bank], toggle wr_bank, wrap wr_addr to 0, all on the same edge.
- Overrun: fir_valid=1 while bank_full[wr_bank]=1 → sample dropped, pointers unchanged, overrun set next cycle and held until reset.
- After done: fir_valid is ignored and does not set overrun.
- FSM states: IDLE, RUN, ANA, FIN.
  - IDLE: if bank_full[rd_bank] & !fft_busy → fft_start=1 for one cycle, fft_bank<=rd_bank, go to RUN. Latency from the completing write edge to fft_start is 1 cycle.
  - RUN: on fft_done → clear bank_full[rd_bank], toggle rd_bank, frame_cnt+1, fft_valid=1 on the next cycle. Then:
    - if new frame_cnt == NUM_FRAMES → ANA, ana_start=1 for one cycle;
    - else → IDLE.
  - ANA: on ana_done → FIN.
  - FIN: done=1; terminal state until reset.
- Simultaneous events:
  - A write completing bank X and fft_done clearing bank Y (X≠Y) on the same edge: both take effect.
  - A write to a bank being cleared on that edge is not possible, because the write is blocked by bank_full.
- fft_done received outside RUN is ignored. ana_done received outside ANA is ignored.
- frame_cnt saturates at NUM_FRAMES.
- Reset mid-frame or mid-FFT: immediate return to the reset state; partially written data is discarded and no pulses are emitted.

Optional Feature:
- Macro FAS_SEQ_ANALYSIS_EN.
- Defined: ANA state present; behaviour as above.
- Undefined: ANA state removed; ana_start tied to 0; ana_done ignored; RUN goes directly to FIN after the last frame, so done rises 1 cycle after the final fft_valid.

Test Plan:
- Reset, then 16 consecutive fir_valid → buf_wr_addr 0..15 on bank 0; bank_full=01; fft_start 1 cycle later with fft_bank=0; next samples go to bank 1 at addr 0.
- fft_busy=1 held across the bank-full edge → no fft_start. Drop fft_busy → fft_start on the next cycle. fft_done → fft_valid 1 cycle later, frame_cnt=1, rd_bank=1.
- Both banks full, FFT withholds fft_done, 1 extra fir_valid → buf_wr_en=0, overrun=1 and sticky, wr_addr unchanged.
- Continuous 1024 samples with fft_done 20 cycles after each fft_start → 64 fft_valid pulses, overrun=0, ana_start once, done=1 one cycle after ana_done; with FAS_SEQ_ANALYSIS_EN undefined, done=1 one cycle after the 64th fft_valid.
- rst=0 asserted at sample 7 of frame 3 → all outputs 0 immediately; after release, the first write targets bank 0 at addr 0 and frame_cnt=0.
- fft_done pulsed in IDLE, ana_done pulsed in RUN → no state change and no output pulses.
